// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with valid/ready handshakes, a 2-entry skid buffer and synchronous flush.
// Optional stall counter port enabled by defining EXE_MEM_STALL_CNT_EN.
module exe_mem_skid_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wb_en,
   input  logic              in_mem_r_en,
   input  logic              in_mem_w_en,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_alu_res,
   input  logic [DATA_W-1:0] in_st_val,
   input  logic [REG_W-1:0]  in_dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_wb_en,
   output logic              out_mem_r_en,
   output logic              out_mem_w_en,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_alu_res,
   output logic [DATA_W-1:0] out_st_val,
   output logic [REG_W-1:0]  out_dest
`ifdef EXE_MEM_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

   typedef struct packed {
      logic              wb_en;
      logic              mem_r_en;
      logic              mem_w_en;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] alu_res;
      logic [DATA_W-1:0] st_val;
      logic [REG_W-1:0]  dest;
   } entry_t;

   state_t state_q, state_d;
   entry_t main_q, main_d, skid_q, skid_d, in_e;
   logic   main_vld_q, skid_vld_q, in_ready_q;
   logic   in_fire, out_fire;

   assign in_e = '{wb_en: in_wb_en, mem_r_en: in_mem_r_en, mem_w_en: in_mem_w_en,
                   pc: in_pc, alu_res: in_alu_res, st_val: in_st_val, dest: in_dest};

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = main_vld_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = in_e;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_d = in_e;
               end else if (in_fire) begin
                  skid_d  = in_e;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = BUSY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Valid bits and in_ready are registered from the next state so MEM back-pressure never reaches EXE combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= (state_d != EMPTY);
         skid_vld_q <= (state_d == FULL);
         in_ready_q <= (state_d != FULL);
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = main_vld_q;
   assign out_wb_en    = main_q.wb_en & main_vld_q;
   assign out_mem_r_en = main_q.mem_r_en & main_vld_q;
   assign out_mem_w_en = main_q.mem_w_en & main_vld_q;
   assign out_pc       = main_q.pc;
   assign out_alu_res  = main_q.alu_res;
   assign out_st_val   = main_q.st_val;
   assign out_dest     = main_q.dest;

`ifdef EXE_MEM_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of cycles MEM holds off a valid entry; flush deliberately leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (main_vld_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/exe_mem_skid_reg.md
Name: exe_mem_skid_reg

Overview:
- Parametrised successor to the EXE→MEM pipeline register.
- Adds valid/ready handshaking in both directions, a 2-entry skid buffer so back-pressure from MEM does not create a combinational ready path into EXE, and a synchronous flush for branch/exception squash.
- Sits between the EXE stage and the MEM stage.
- Carries the writeback/memory-read/memory-write controls, PC, ALU result, store value and destination register index.

Parameters:
- DATA_W, 32, width of pc, alu_res and st_val.
- REG_W, 5, width of the destination register index.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  EXE presents a valid instruction.
- in_ready  out  1  block can accept; registered, equals NOT skid_valid.
- in_wb_en, in_mem_r_en, in_mem_w_en  in  1 each  control bits from EXE.
- in_pc, in_alu_res, in_st_val  in  DATA_W each  payload from EXE.
- in_dest  in  REG_W  destination register index.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM stage accepts this cycle.
- out_wb_en, out_mem_r_en, out_mem_w_en  out  1 each  registered controls, gated by out_valid.
- out_pc, out_alu_res, out_st_val  out  DATA_W each  registered payload.
- out_dest  out  REG_W  registered destination index.
- stall_cnt  out  16  present only with EXE_MEM_STALL_CNT_EN.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: a main entry, which drives the outputs, and a skid entry. Each holds the controls, payload and a valid bit.
- Reset (asynchronous, takes effect immediately):
  - state EMPTY; both valid bits 0; all payload and control registers 0.
  - out_valid=0; in_ready=1; stall_cnt=0.
- States:
  - EMPTY: main invalid, skid invalid.
  - BUSY: main valid, skid invalid.
  - FULL: main valid, skid valid.
- Transitions, evaluated on the rising clk edge when flush=0:
  - EMPTY: in_fire → load main, go to BUSY.
  - BUSY, in_fire & out_fire → main ← input, stay in BUSY (back-to-back, 1 instruction per cycle).
  - BUSY, in_fire & !out_fire → skid ← input, go to FULL.
  - BUSY, !in_fire & out_fire → go to EMPTY.
  - BUSY, neither → hold.
  - FULL: in_ready=0, so no input is accepted. out_fire → main ← skid, go to BUSY; otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when the block is EMPTY or draining.
- Gating: out_wb_en, out_mem_r_en and out_mem_w_en are forced to 0 whenever out_valid=0, so bubbles never write memory or the register file. Payload outputs are don't-care while invalid but must hold stable in BUSY/FULL until out_fire.
- Flush:
  - On a rising edge with flush=1, go to EMPTY and clear both valid bits, whatever the handshakes are doing.
  - flush has priority over a simultaneous in_fire (the input is dropped) and over out_fire.
  - in_ready is 1 on the cycle after a flush.
- Ordering: strict FIFO order; the skid entry is never presented before the main entry.
- Reset mid-operation discards both entries immediately.

Optional Feature:
- Macro: EXE_MEM_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with out_valid & !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the stall_cnt port and its counter logic are absent.

Test Plan:
- Reset then stream: assert reset, release; drive in_valid=1 for 4 cycles with alu_res=1,2,3,4 and out_ready=1 → out_valid rises 1 cycle later; out_alu_res=1,2,3,4 on consecutive cycles; in_ready stays 1.
- Back-pressure: out_ready=0, send alu_res=0xA then 0xB → state FULL; in_ready=0 on the next cycle; out_alu_res stays 0xA. Raise out_ready → 0xA then 0xB delivered, in_ready returns to 1.
- Flush with input: state FULL; assert flush together with in_valid=1 (dest=7) → next cycle out_valid=0, out_wb_en=0, in_ready=1; dest 7 never appears at the output.
- Control gating: send in_mem_w_en=1, then idle → once drained, out_mem_w_en=0 while out_valid=0.
- Async reset mid-operation: state FULL; pulse reset between clock edges → out_valid=0 and in_ready=1 before the next edge; all outputs 0.
- With EXE_MEM_STALL_CNT_EN defined: hold out_valid=1 and out_ready=0 for 5 cycles → stall_cnt=5; a subsequent flush leaves stall_cnt=5.
